// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity mode encodings, RX FSM states, 2-of-3 vote helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous line; resets to 1 so reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_v2.sv
// Oversampled UART receiver with parity, break and overrun detection and a valid/ready output slot.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote over the last three oversamples of each bit.
module uart_rx_v2
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic [1:0]      par_mode,
    output logic [DBIT-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            e_parity,
    output logic            e_frame,
    output logic            e_break,
    output logic            e_overrun,
    output logic            busy
);

    localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE/2);
`else
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE/2 - 1);
`endif
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    state_t            state, state_n;
    logic [SW-1:0]     s, s_n;
    logic [NW-1:0]     n, n_n;
    logic [DBIT-1:0]   b, b_n;
    logic [1:0]        pm_reg, pm_n;
    logic              par, par_n;
    logic              rxs, bit_val, par_en, done, brk, pe;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [SW-1:0] S_BIT_M3  = SW'(OVERSAMPLE - 3);
    localparam logic [SW-1:0] S_BIT_M2  = SW'(OVERSAMPLE - 2);
    localparam logic [SW-1:0] S_STOP_M3 = SW'(SB_TICK - 3);
    localparam logic [SW-1:0] S_STOP_M2 = SW'(SB_TICK - 2);

    logic          smp_a, smp_b;
    logic [SW-1:0] s_m3, s_m2;

    always_comb begin
        s_m3 = (state == STOP) ? S_STOP_M3 : S_BIT_M3;
        s_m2 = (state == STOP) ? S_STOP_M2 : S_BIT_M2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else if (s_tick && (state == DATA || state == PARITY || state == STOP)) begin
            if (s == s_m3) smp_a <= rxs;
            if (s == s_m2) smp_b <= rxs;
        end
    end

    assign bit_val = maj3(smp_a, smp_b, rxs);
`else
    assign bit_val = rxs;
`endif

    assign par_en = (pm_reg == PAR_EVEN) || (pm_reg == PAR_ODD);
    assign pe     = par_en && ((^b ^ par) != (pm_reg == PAR_ODD));
    // A break is an all-zero frame, including parity and stop.
    assign brk    = (b == '0) && (!par_en || !par) && !bit_val;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            b      <= '0;
            pm_reg <= PAR_NONE;
            par    <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            n      <= n_n;
            b      <= b_n;
            pm_reg <= pm_n;
            par    <= par_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        pm_n    = pm_reg;
        par_n   = par;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    s_n     = '0;
                    pm_n    = par_mode;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_HALF) begin
                        state_n = rxs ? IDLE : DATA;
                        s_n     = '0;
                        n_n     = '0;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_n = '0;
                        b_n = {bit_val, b[DBIT-1:1]};
                        if (n == N_LAST) begin
                            n_n     = '0;
                            state_n = par_en ? PARITY : STOP;
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        par_n   = bit_val;
                        s_n     = '0;
                        state_n = STOP;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        s_n     = '0;
                        done    = 1'b1;
                        state_n = brk ? BRK_WAIT : IDLE;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Single-entry output slot; a frame arriving while it is full is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            e_parity   <= 1'b0;
            e_frame    <= 1'b0;
            e_break    <= 1'b0;
            e_overrun  <= 1'b0;
        end else if (done) begin
            if (!dout_valid || dout_ready) begin
                dout       <= b;
                dout_valid <= 1'b1;
                e_parity   <= pe;
                e_frame    <= !bit_val;
                e_break    <= brk;
                e_overrun  <= 1'b0;
            end else begin
                e_overrun  <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            e_parity   <= 1'b0;
            e_frame    <= 1'b0;
            e_break    <= 1'b0;
            e_overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_v2.sv
// Randomised and directed bench for uart_rx_v2 (DBIT=8 and DBIT=7 instances on a shared line).
module tb_uart_rx_v2;

    localparam int OS  = 16;
    localparam int SBT = 16;

    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, s_tick = 1'b0, dout_ready = 1'b0;
    logic [1:0] par_mode = 2'd0;

    logic [7:0] dout8;
    logic       dv8, ep8, ef8, eb8, eo8, busy8;
    logic [6:0] dout7;
    logic       dv7, ep7, ef7, eb7, eo7, busy7;

    uart_rx_v2 #(.DBIT(8), .OVERSAMPLE(OS), .SB_TICK(SBT)) dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .par_mode(par_mode),
        .dout(dout8), .dout_valid(dv8), .dout_ready(dout_ready),
        .e_parity(ep8), .e_frame(ef8), .e_break(eb8), .e_overrun(eo8), .busy(busy8)
    );

    uart_rx_v2 #(.DBIT(7), .OVERSAMPLE(OS), .SB_TICK(SBT)) dut7 (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .par_mode(par_mode),
        .dout(dout7), .dout_valid(dv7), .dout_ready(dout_ready),
        .e_parity(ep7), .e_frame(ef7), .e_break(eb7), .e_overrun(eo7), .busy(busy7)
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    always @(posedge clk) begin
        tdiv   <= (tdiv == 3) ? 0 : tdiv + 1;
        s_tick <= (tdiv == 3);
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word monitor on the DBIT=8 instance.
    int         n_rise = 0, v_cyc = 0;
    logic       pv = 1'b0;
    logic [7:0] cap_d = '0;
    logic [3:0] cap_f = '0;
    always @(negedge clk) begin
        if (dv8) begin
            v_cyc <= v_cyc + 1;
            cap_d <= dout8;
            cap_f <= {ep8, ef8, eb8, eo8};
            if (!pv) n_rise <= n_rise + 1;
        end
        pv <= dv8;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic v, input int nt);
        @(negedge clk);
        rx = v;
        repeat (nt) begin
            do @(negedge clk); while (!s_tick);
            @(posedge clk);
        end
    endtask

    // Missing stop: line low for the first 12 ticks of the stop slot, then back high.
    task automatic send_frame(input logic [8:0] d, input int nb, input logic [1:0] pm,
                              input logic p, input logic stp);
        @(negedge clk);
        par_mode = pm;
        send_bit(1'b0, OS);
        for (int i = 0; i < nb; i++) send_bit(d[i], OS);
        if (pm == 2'd1 || pm == 2'd2) send_bit(p, OS);
        if (stp) send_bit(1'b1, SBT);
        else begin
            send_bit(1'b0, 12);
            send_bit(1'b1, SBT - 12);
        end
        send_bit(1'b1, 4);
    endtask

    task automatic accept();
        @(negedge clk);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    // Reference slot model
    logic       m_v = 0, m_pe = 0, m_fe = 0, m_br = 0, m_ov = 0;
    logic [7:0] m_d = 0;

    task automatic model_frame(input logic [7:0] d, input logic [1:0] pm, input logic p, input logic stp);
        logic pen, pe, br;
        pen = (pm == 2'd1) || (pm == 2'd2);
        pe  = (pm == 2'd1) ? (^d ^ p) : (pm == 2'd2) ? !(^d ^ p) : 1'b0;
        br  = (d == 8'h00) && (!pen || !p) && !stp;
        if (!m_v) begin
            m_v = 1; m_d = d; m_pe = pe; m_fe = !stp; m_br = br; m_ov = 0;
        end else begin
            m_ov = 1;
        end
    endtask

    initial begin
        int r0, v0;
        repeat (4) @(negedge clk);
        chk("rst_valid", dv8, 0);
        chk("rst_dout", dout8, 0);
        chk("rst_flags", {ep8, ef8, eb8, eo8}, 0);
        chk("rst_busy", busy8, 0);
        reset = 1'b0;
        send_bit(1'b1, 4);

        // Basic 8N1 with ready held high
        dout_ready = 1'b1;
        r0 = n_rise; v0 = v_cyc;
        send_frame(9'h0A5, 8, 2'd0, 1'b0, 1'b1);
        send_bit(1'b1, 2);
        chk("a5_words", n_rise - r0, 1);
        chk("a5_pulse", v_cyc - v0, 1);
        chk("a5_dout", cap_d, 8'hA5);
        chk("a5_flags", cap_f, 4'h0);
        dout_ready = 1'b0;

        // Even parity, wrong then right
        send_frame(9'h003, 8, 2'd1, 1'b1, 1'b1);
        @(negedge clk);
        chk("par1_dout", dout8, 8'h03);
        chk("par1_pe", ep8, 1);
        accept();
        send_frame(9'h003, 8, 2'd1, 1'b0, 1'b1);
        @(negedge clk);
        chk("par0_dout", dout8, 8'h03);
        chk("par0_pe", ep8, 0);
        accept();
        @(negedge clk);
        chk("acc_valid", dv8, 0);

        // False start
        r0 = n_rise;
        send_bit(1'b0, 4);
        send_bit(1'b1, 5);
        @(negedge clk);
        chk("fs_busy", busy8, 0);
        chk("fs_words", n_rise - r0, 0);

        // Overrun
        send_frame(9'h011, 8, 2'd0, 1'b0, 1'b1);
        send_frame(9'h022, 8, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovr_dout", dout8, 8'h11);
        chk("ovr_flag", eo8, 1);
        chk("ovr_valid", dv8, 1);
        @(negedge clk);
        dout_ready = 1'b1;
        @(negedge clk);
        chk("ovr_acc_valid", dv8, 0);
        chk("ovr_acc_flag", eo8, 0);
        r0 = n_rise;
        send_frame(9'h033, 8, 2'd0, 1'b0, 1'b1);
        send_bit(1'b1, 2);
        chk("ovr2_words", n_rise - r0, 1);
        chk("ovr2_dout", cap_d, 8'h33);
        chk("ovr2_flag", cap_f[0], 0);
        dout_ready = 1'b0;

        // Break: line low for three frame times
        r0 = n_rise;
        @(negedge clk);
        par_mode = 2'd0;
        send_bit(1'b0, 3 * 10 * OS);
        @(negedge clk);
        chk("brk_busy", busy8, 1);
        chk("brk_valid", dv8, 1);
        chk("brk_dout", dout8, 0);
        chk("brk_flags", {ep8, ef8, eb8}, 3'b011);
        send_bit(1'b1, 3);
        @(negedge clk);
        chk("brk_idle", busy8, 0);
        send_bit(1'b1, 40);
        chk("brk_words", n_rise - r0, 1);
        accept();
        m_v = 0;

        // Randomised frames against the slot model
        for (int it = 0; it < 20; it++) begin
            int nfr;
            nfr = ($urandom_range(0, 3) == 0) ? 2 : 1;
            for (int f = 0; f < nfr; f++) begin
                logic [7:0] d;
                logic [1:0] pm;
                logic       p, stp, bad;
                d   = 8'($urandom);
                if ($urandom_range(0, 4) == 0) d = 8'h00;
                pm  = 2'($urandom_range(0, 3));
                bad = ($urandom_range(0, 2) == 0);
                p   = ^d ^ (pm == 2'd2) ^ bad;
                stp = ($urandom_range(0, 3) != 0);
                send_frame({1'b0, d}, 8, pm, p, stp);
                model_frame(d, pm, p, stp);
            end
            @(negedge clk);
            chk("rnd_valid", dv8, m_v);
            chk("rnd_dout", dout8, m_d);
            chk("rnd_flags", {ep8, ef8, eb8, eo8}, {m_pe, m_fe, m_br, m_ov});
            accept();
            m_v = 0;
            @(negedge clk);
            chk("rnd_clear", {dv8, ep8, ef8, eb8, eo8}, 5'b0);
        end

        // DBIT=7, odd parity correct, stop missing
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send_bit(1'b1, 4);
        send_frame(9'h041, 7, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        chk("d7_valid", dv7, 1);
        chk("d7_dout", dout7, 7'h41);
        chk("d7_flags", {ep7, ef7, eb7}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_v2.md
Name: uart_rx_v2

Overview:
Parametrised successor UART receiver: oversampled serial input to a parallel word with valid/ready output handshake.
- Runtime-selectable parity.
- Input synchroniser, false-start rejection, break detection, overrun detection.
- Sits between the baud-rate tick generator (s_tick) and the RX FIFO / command decoder.

Parameters:
DBIT, 8, data bits per frame (5..9)
OVERSAMPLE, 16, s_tick pulses per bit period (even, >=8)
SB_TICK, 16, s_tick pulses for the stop interval (OVERSAMPLE = 1 stop, 1.5*OVERSAMPLE = 1.5 stop, 2*OVERSAMPLE = 2 stop)

Ports:
clk  in  1  system clock
reset  in  1  reset
rx  in  1  asynchronous serial line, idle high
s_tick  in  1  oversample enable pulse, one clk wide
par_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = none
dout  out  DBIT  received word, LSB = first bit on line
dout_valid  out  1  dout and flags hold a complete frame
dout_ready  in  1  consumer accepts the word when dout_valid && dout_ready
e_parity  out  1  parity mismatch for the held word
e_frame  out  1  stop bit sampled low for the held word
e_break  out  1  held word is a break condition
e_overrun  out  1  at least one frame was dropped while the held word waited
busy  out  1  FSM not in IDLE

Behaviour:
- Single clock clk. Reset is synchronous and active-high on port reset. All state updates on posedge clk.
- Reset values: FSM = IDLE; all counters = 0; synchroniser flops = 1; dout = 0; all outputs = 0.
- rx passes through a 2-flop synchroniser; the FSM uses only the synchronised value rxs.
- Counters:
  - s counter width $clog2(max(OVERSAMPLE, SB_TICK)).
  - n counter width $clog2(DBIT).
  - All increments wrap-free: each counter is cleared on every state exit.
- FSM states:
  - IDLE: rxs == 0 -> START, s = 0, latch par_mode into pm_reg. par_mode changes mid-frame are ignored.
  - START:
    - Each s_tick increments s.
    - At s == OVERSAMPLE/2-1: if rxs == 1 (false start) -> IDLE, no output. Otherwise -> DATA, s = 0, n = 0.
  - DATA:
    - Each s_tick increments s.
    - At s == OVERSAMPLE-1: shift rxs in from the MSB side (after DBIT shifts, dout is LSB-first correct) and set s = 0.
    - If n == DBIT-1: go to PARITY when pm_reg is 1 or 2, else STOP. Otherwise n++.
  - PARITY:
    - At s == OVERSAMPLE-1: capture par_bit, then -> STOP.
    - Even: error if XOR(data, par_bit) == 1. Odd: error if XOR(data, par_bit) == 0.
  - STOP:
    - At s == SB_TICK-1: sample the stop bit and complete the frame (see output stage).
    - Break = data all zero AND (no parity OR par_bit == 0) AND stop == 0. Break -> BRK_WAIT; otherwise -> IDLE.
  - BRK_WAIT: remain until rxs == 1, then -> IDLE. No start detection while in this state.
- Output stage, on frame completion:
  - Slot empty, or dout_valid && dout_ready in the same cycle: load dout, e_parity, e_frame, e_break; set dout_valid = 1; clear e_overrun.
  - Slot full and not accepted this cycle: drop the new frame, keep the held word, set e_overrun = 1.
  - dout_valid && dout_ready with no completion: dout_valid = 0 and all flags = 0 the next cycle. dout is held.
  - Latency: dout_valid rises exactly 1 clk after the STOP-final s_tick.
- No s_tick: the FSM holds state indefinitely. Consecutive frames need no idle gap beyond the stop interval.
- Reset mid-frame: immediate return to IDLE. The pending word and flags are discarded.

Optional Feature:
UART_RX_MAJORITY_EN.
- Defined:
  - START exits at s == OVERSAMPLE/2 instead of OVERSAMPLE/2-1.
  - Data, parity and stop values are the 2-of-3 majority of rxs at s = W-3, W-2, W-1, where W = OVERSAMPLE (SB_TICK for stop).
  - The decision is made at s == W-1.
  - The false-start check remains a single sample.
- Undefined: single sample at s == W-1 as above. No extra sample registers.

Decomposition:
- uart_pkg holds:
  - par_mode encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state localparams IDLE, START, DATA, PARITY, STOP, BRK_WAIT (3-bit).
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1, reusable by other RX paths.
- Parity is an inline XOR reduction; no separate module.

Test Plan:
- DBIT=8, par_mode=0, OVERSAMPLE=16, send 0xA5 + stop, dout_ready=1 -> dout=0xA5, dout_valid one pulse, all error flags 0.
- par_mode=1, send 0x03 with parity bit 1 -> dout=0x03, e_parity=1. Repeat with parity bit 0 -> e_parity=0.
- rx low for 4 s_ticks, then high -> no dout_valid, FSM back in IDLE, busy drops within 5 s_ticks.
- dout_ready=0, send 0x11 then 0x22 -> dout=0x11, e_overrun=1. Raise ready, then send 0x33 -> dout=0x33, e_overrun=0.
- rx held low for 3 frame times -> one word 0x00 with e_break=1 and e_frame=1, busy until rx returns high, no second word.
- DBIT=7, par_mode=2, stop missing on 0x41 -> dout=0x41, e_frame=1, e_parity=0 when the parity bit is correct.
